// File: rtl/mult18_pkg.sv
// Shared constants, FSM state type and saturation bounds for the mult18 product accumulator.
package mult18_pkg;

    localparam int unsigned PROD_W    = 36;
    localparam int unsigned ACC_W_DEF = 48;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    // Bounds are returned 64 bits wide; callers truncate to their own width (w <= 64).
    function automatic logic signed [63:0] sat_max(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/mult18_mac_acc_if.sv
// Product-in / frame-result-out bundle between the multiplier and the accumulator.
interface mult18_mac_acc_if import mult18_pkg::*; #(
    parameter int unsigned ACC_W = ACC_W_DEF
);
    logic                    CE;
    logic                    CLR;
    logic signed [PROD_W-1:0] P;
    logic                    P_VALID;
    logic signed [ACC_W-1:0] DOUT;
    logic                    DOUT_VALID;
    logic                    OVF;

    modport master (
        output CE, CLR, P, P_VALID,
        input  DOUT, DOUT_VALID, OVF
    );

    modport slave (
        input  CE, CLR, P, P_VALID,
        output DOUT, DOUT_VALID, OVF
    );
endinterface

// File: rtl/mult18_sat_add.sv
// Signed ACC_W-bit adder that clamps to the representable range on overflow.
module mult18_sat_add import mult18_pkg::*; #(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [ACC_W-1:0] b,
    output logic signed [ACC_W-1:0] sum,
    output logic                    ovf
);
    logic signed [ACC_W-1:0] raw;

    always_comb begin
        raw = a + b;
        ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
        if (ovf) begin
            sum = a[ACC_W-1] ? ACC_W'(sat_min(ACC_W)) : ACC_W'(sat_max(ACC_W));
        end else begin
            sum = raw;
        end
    end
endmodule

// File: rtl/mult18_mac_acc.sv
// Accumulates LEN valid products into one saturating signed result per frame.
module mult18_mac_acc import mult18_pkg::*; #(
    parameter int unsigned LEN   = 16,
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input logic             C,
    input logic             R,
    mult18_mac_acc_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(LEN + 1);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] acc;
    logic                    ovf_i;

    logic signed [ACC_W-1:0] p_ext;
    logic signed [ACC_W-1:0] add_a;
    logic signed [ACC_W-1:0] sum;
    logic                    add_ovf;
    logic                    last;

    assign p_ext = ACC_W'(bus.P);
    // First term of a frame adds to zero, so IDLE and ACCUM share the one adder.
    assign add_a = (state == IDLE) ? '0 : acc;
    assign last  = (cnt == CNT_W'(LEN - 1));

    mult18_sat_add #(.ACC_W(ACC_W)) u_sat_add (
        .a   (add_a),
        .b   (p_ext),
        .sum (sum),
        .ovf (add_ovf)
    );

    always_ff @(posedge C) begin
        if (R) begin
            state          <= IDLE;
            cnt            <= '0;
            acc            <= '0;
            ovf_i          <= 1'b0;
            bus.DOUT       <= '0;
            bus.DOUT_VALID <= 1'b0;
            bus.OVF        <= 1'b0;
        end else if (bus.CE) begin
            bus.DOUT_VALID <= 1'b0;
            if (bus.CLR) begin
                state <= IDLE;
                cnt   <= '0;
                acc   <= '0;
                ovf_i <= 1'b0;
            end else if (bus.P_VALID) begin
                if (last) begin
                    bus.DOUT       <= sum;
                    bus.OVF        <= ovf_i | add_ovf;
                    bus.DOUT_VALID <= 1'b1;
                    state          <= IDLE;
                    cnt            <= '0;
                    acc            <= '0;
                    ovf_i          <= 1'b0;
                end else begin
                    state <= ACCUM;
                    cnt   <= cnt + CNT_W'(1);
                    acc   <= sum;
                    ovf_i <= ovf_i | add_ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_mult18_mac_acc.sv
// Drives three accumulator configurations (LEN4/48b, LEN2/36b, LEN1/48b) with shared stimulus.
module tb_mult18_mac_acc;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult18_mac_acc_if #(.ACC_W(48)) if4 ();
    mult18_mac_acc_if #(.ACC_W(36)) if2 ();
    mult18_mac_acc_if #(.ACC_W(48)) if1 ();

    mult18_mac_acc #(.LEN(4), .ACC_W(48)) u4 (.C(clk), .R(rst), .bus(if4));
    mult18_mac_acc #(.LEN(2), .ACC_W(36)) u2 (.C(clk), .R(rst), .bus(if2));
    mult18_mac_acc #(.LEN(1), .ACC_W(48)) u1 (.C(clk), .R(rst), .bus(if1));

    int errors = 0;
    int checks = 0;

    int unsigned lens [3] = '{4, 2, 1};
    int unsigned wids [3] = '{48, 36, 48};

    // Reference: running clamped sum per frame, plus expected registered outputs.
    longint msum  [3];
    int     mcnt  [3];
    bit     movf  [3];
    longint edout [3];
    bit     edv   [3];
    bit     eovf  [3];

    longint ddout [3];
    bit     ddv   [3];
    bit     dovf  [3];

    task automatic model_step(input int i, input logic r, input logic ce, input logic clr,
                              input logic pv, input logic signed [35:0] p);
        longint hi, lo, x, t;
        bit     o;
        hi = (longint'(1) <<< (wids[i] - 1)) - 1;
        lo = -(longint'(1) <<< (wids[i] - 1));
        x  = p;
        if (r) begin
            msum[i] = 0; mcnt[i] = 0; movf[i] = 0;
            edout[i] = 0; edv[i] = 0; eovf[i] = 0;
        end else if (ce) begin
            edv[i] = 0;
            if (clr) begin
                msum[i] = 0; mcnt[i] = 0; movf[i] = 0;
            end else if (pv) begin
                t = msum[i] + x;
                o = 0;
                if (t > hi) begin t = hi; o = 1; end
                if (t < lo) begin t = lo; o = 1; end
                mcnt[i] = mcnt[i] + 1;
                if (mcnt[i] == int'(lens[i])) begin
                    edout[i] = t; eovf[i] = movf[i] | o; edv[i] = 1;
                    msum[i] = 0; mcnt[i] = 0; movf[i] = 0;
                end else begin
                    msum[i] = t; movf[i] = movf[i] | o;
                end
            end
        end
    endtask

    task automatic cycle(input logic r, input logic ce, input logic clr, input logic pv,
                         input logic signed [35:0] p);
        @(negedge clk);
        rst = r;
        if4.CE = ce; if4.CLR = clr; if4.P_VALID = pv; if4.P = p;
        if2.CE = ce; if2.CLR = clr; if2.P_VALID = pv; if2.P = p;
        if1.CE = ce; if1.CLR = clr; if1.P_VALID = pv; if1.P = p;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) model_step(i, r, ce, clr, pv, p);
        ddout[0] = if4.DOUT; ddv[0] = if4.DOUT_VALID; dovf[0] = if4.OVF;
        ddout[1] = if2.DOUT; ddv[1] = if2.DOUT_VALID; dovf[1] = if2.OVF;
        ddout[2] = if1.DOUT; ddv[2] = if1.DOUT_VALID; dovf[2] = if1.OVF;
    endtask

    task automatic feed(input logic signed [35:0] p);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, p);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    endtask

    task automatic clear();
        cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ddout[i] !== 0) begin
                errors++; $display("FAIL reset_dout[%0d] got %0d want 0", i, ddout[i]);
            end
            checks++;
            if (ddv[i] !== 1'b0 || dovf[i] !== 1'b0) begin
                errors++; $display("FAIL reset_flags[%0d] got dv=%0b ovf=%0b want 0 0", i, ddv[i], dovf[i]);
            end
        end
    endtask

    task automatic test_basic();
        clear();
        feed(3); feed(5); feed(-2);
        checks++;
        if (ddv[0] !== 1'b0) begin
            errors++; $display("FAIL basic_early_dv got %0b want 0", ddv[0]);
        end
        feed(10);
        checks++;
        if (ddv[0] !== 1'b1 || ddout[0] !== 16 || dovf[0] !== 1'b0) begin
            errors++; $display("FAIL basic_result got dv=%0b dout=%0d ovf=%0b want 1 16 0", ddv[0], ddout[0], dovf[0]);
        end
        idle();
        checks++;
        if (ddv[0] !== 1'b0 || ddout[0] !== 16) begin
            errors++; $display("FAIL basic_hold got dv=%0b dout=%0d want 0 16", ddv[0], ddout[0]);
        end
    endtask

    task automatic test_back_to_back();
        clear();
        feed(1); feed(2);
        idle(); idle(); idle();
        feed(3); feed(4);
        checks++;
        if (ddv[0] !== 1'b1 || ddout[0] !== 10) begin
            errors++; $display("FAIL gap_result got dv=%0b dout=%0d want 1 10", ddv[0], ddout[0]);
        end
        for (int k = 0; k < 3; k++) begin
            feed(-1);
            checks++;
            if (ddv[0] !== 1'b0) begin
                errors++; $display("FAIL b2b_early_dv[%0d] got %0b want 0", k, ddv[0]);
            end
        end
        feed(-1);
        checks++;
        if (ddv[0] !== 1'b1 || ddout[0] !== -4 || dovf[0] !== 1'b0) begin
            errors++; $display("FAIL b2b_result got dv=%0b dout=%0d ovf=%0b want 1 -4 0", ddv[0], ddout[0], dovf[0]);
        end
    endtask

    task automatic test_saturation();
        clear();
        feed(36'sh7FFFFFFFF); feed(36'sh7FFFFFFFF);
        checks++;
        if (ddv[1] !== 1'b1 || ddout[1] !== 64'sd34359738367 || dovf[1] !== 1'b1) begin
            errors++; $display("FAIL sat_pos got dv=%0b dout=%0d ovf=%0b want 1 34359738367 1", ddv[1], ddout[1], dovf[1]);
        end
        feed(1); feed(1);
        checks++;
        if (ddv[1] !== 1'b1 || ddout[1] !== 2 || dovf[1] !== 1'b0) begin
            errors++; $display("FAIL sat_next got dv=%0b dout=%0d ovf=%0b want 1 2 0", ddv[1], ddout[1], dovf[1]);
        end
        feed(36'sh800000000); feed(36'sh800000000);
        checks++;
        if (ddv[1] !== 1'b1 || ddout[1] !== -64'sd34359738368 || dovf[1] !== 1'b1) begin
            errors++; $display("FAIL sat_neg got dv=%0b dout=%0d ovf=%0b want 1 -34359738368 1", ddv[1], ddout[1], dovf[1]);
        end
    endtask

    task automatic test_clr();
        int pulses;
        clear();
        feed(2); feed(2);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 100);
        checks++;
        if (ddv[0] !== 1'b0) begin
            errors++; $display("FAIL clr_dv got %0b want 0", ddv[0]);
        end
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            feed(1);
            if (ddv[0]) pulses++;
        end
        checks++;
        if (pulses !== 1 || ddout[0] !== 4) begin
            errors++; $display("FAIL clr_result got pulses=%0d dout=%0d want 1 4", pulses, ddout[0]);
        end
    endtask

    task automatic test_ce_priority();
        int pulses;
        clear();
        feed(1); feed(2);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 1'b0, logic'(k % 2 == 0), 1000);
        feed(3); feed(4);
        checks++;
        if (ddv[0] !== 1'b1 || ddout[0] !== 10) begin
            errors++; $display("FAIL ce_result got dv=%0b dout=%0d want 1 10", ddv[0], ddout[0]);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (ddv[0] !== 1'b1) begin
            errors++; $display("FAIL ce_dv_hold got %0b want 1", ddv[0]);
        end
        idle();
        checks++;
        if (ddv[0] !== 1'b0) begin
            errors++; $display("FAIL ce_dv_drop got %0b want 0", ddv[0]);
        end
        feed(7); feed(7);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 5);
        checks++;
        if (ddout[0] !== 0 || ddv[0] !== 1'b0 || dovf[0] !== 1'b0) begin
            errors++; $display("FAIL r_over_ce got dout=%0d dv=%0b ovf=%0b want 0 0 0", ddout[0], ddv[0], dovf[0]);
        end
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            feed(1);
            if (ddv[0]) pulses++;
        end
        feed(1);
        checks++;
        if (pulses !== 0 || ddv[0] !== 1'b1 || ddout[0] !== 4) begin
            errors++; $display("FAIL r_restart got early=%0d dv=%0b dout=%0d want 0 1 4", pulses, ddv[0], ddout[0]);
        end
    endtask

    task automatic test_len1();
        clear();
        for (int k = 0; k < 3; k++) begin
            feed(-7);
            checks++;
            if (ddv[2] !== 1'b1 || ddout[2] !== -7 || dovf[2] !== 1'b0) begin
                errors++; $display("FAIL len1_pass[%0d] got dv=%0b dout=%0d ovf=%0b want 1 -7 0", k, ddv[2], ddout[2], dovf[2]);
            end
        end
        idle();
        checks++;
        if (ddv[2] !== 1'b0 || ddout[2] !== -7) begin
            errors++; $display("FAIL len1_hold got dv=%0b dout=%0d want 0 -7", ddv[2], ddout[2]);
        end
    endtask

    task automatic test_random();
        logic r, ce, clr, pv;
        logic signed [35:0] p;
        for (int n = 0; n < 600; n++) begin
            r   = ($urandom_range(99) == 0);
            ce  = ($urandom_range(9) != 0);
            clr = ($urandom_range(29) == 0);
            pv  = ($urandom_range(9) < 7);
            case ($urandom_range(3))
                0:       p = 36'sh7FFFFFFFF;
                1:       p = 36'sh800000000;
                default: p = {4'($urandom), 32'($urandom)};
            endcase
            cycle(r, ce, clr, pv, p);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (ddv[i] !== edv[i] || ddout[i] !== edout[i] || (edv[i] && dovf[i] !== eovf[i])) begin
                    errors++;
                    $display("FAIL rand[%0d] dut%0d got dv=%0b dout=%0d ovf=%0b want %0b %0d %0b",
                             n, i, ddv[i], ddout[i], dovf[i], edv[i], edout[i], eovf[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_saturation();
        test_clr();
        test_ce_priority();
        test_len1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
